// File: rtl/uart_frame_monitor.sv
// uart_frame_monitor: oversampled UART line checker with error pulses, sticky status and counters
module uart_frame_monitor #(
  parameter int OVS = 16,
  parameter int DIV_W = 8,
  parameter int TOL = 2,
  parameter int CNT_W = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             uart_net,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  input  logic             err_clr,
  output logic             frame_valid,
  output logic [7:0]       frame_data,
  output logic             par_err,
  output logic             frm_err,
  output logic             glitch_err,
  output logic             baud_err,
  output logic [3:0]       err_status,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int PH_W = $clog2(OVS) + DIV_W + 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic             sync1, sync2, sync3;
  logic [2:0]       state;
  logic [PH_W-1:0]  phase, per, half;
  logic [DIV_W-1:0] div_l;
  logic [1:0]       bits_l;
  logic             par_en_l, par_odd_l, stop2_l;
  logic             stop_idx, par_flag, bdone;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             fall, line_edge, smp, wrap, in_win, in_bits, par_bad;
  logic             end_n, v_n, p_n, f_n, g_n, b_n;
  logic [2:0]       n_err;
  logic [CNT_W:0]   err_sum;

  // bit timing, edge detection and the pulses that fire on this edge
  always_comb begin
    per = PH_W'(OVS) * (PH_W'(div_l) + PH_W'(1));
    half = per >> 1;
    fall = sync3 & ~sync2;
    line_edge = sync3 ^ sync2;
    smp = (state != IDLE) && (phase == half);
    wrap = phase == per - PH_W'(1);
    in_win = (phase >= PH_W'(TOL + 1)) && (phase <= per - PH_W'(TOL + 1));
    in_bits = (state == DATA) || (state == PARITY) || (state == STOP);
    par_bad = (^shreg ^ sync2) != par_odd_l;
    g_n = cfg_en && (state == START) && smp && sync2;
    b_n = cfg_en && in_bits && line_edge && in_win && !bdone;
    end_n = cfg_en && (state == STOP) && smp && (!sync2 || !stop2_l || stop_idx);
    v_n = end_n && sync2;
    f_n = end_n && !sync2;
    p_n = end_n && par_flag;
    n_err = {2'b0, p_n} + {2'b0, f_n} + {2'b0, g_n} + {2'b0, b_n};
    err_sum = {1'b0, err_cnt} + (CNT_W + 1)'(n_err);
  end

  // two-flop synchroniser plus one stage for edge detection, idle high
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) {sync1, sync2, sync3} <= 3'b111;
    else {sync1, sync2, sync3} <= {uart_net, sync1, sync2};

  // frame sequencer: config is captured at the start edge and held for the whole frame
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      state <= IDLE;
      phase <= '0;
      div_l <= '0;
      bits_l <= '0;
      par_en_l <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l <= 1'b0;
      stop_idx <= 1'b0;
      par_flag <= 1'b0;
      bdone <= 1'b0;
      bit_idx <= '0;
      shreg <= '0;
    end else if (!cfg_en) state <= IDLE;
    else begin
      phase <= wrap ? '0 : phase + 1'b1;
      bdone <= b_n | (bdone & ~wrap);
      case (state)
        IDLE: if (fall) begin
          state <= START;
          phase <= '0;
          div_l <= cfg_div;
          bits_l <= cfg_data_bits;
          par_en_l <= cfg_par_en;
          par_odd_l <= cfg_par_odd;
          stop2_l <= cfg_stop2;
          stop_idx <= 1'b0;
          par_flag <= 1'b0;
          bdone <= 1'b0;
          bit_idx <= '0;
          shreg <= '0;
        end
        START: if (smp) state <= sync2 ? IDLE : DATA;
        DATA: if (smp) begin
          shreg[bit_idx] <= sync2;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd4 + {1'b0, bits_l}) state <= par_en_l ? PARITY : STOP;
        end
        PARITY: if (smp) begin
          par_flag <= par_bad;
          state <= STOP;
        end
        STOP: if (smp) begin
          stop_idx <= 1'b1;
          if (end_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  // registered pulses, held data, sticky status and saturating counters
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      frame_valid <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      glitch_err <= 1'b0;
      baud_err <= 1'b0;
      frame_data <= '0;
      err_status <= '0;
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      frame_valid <= v_n;
      par_err <= p_n;
      frm_err <= f_n;
      glitch_err <= g_n;
      baud_err <= b_n;
      if (v_n) frame_data <= shreg;
      err_status <= err_clr ? '0 : err_status | {b_n, g_n, f_n, p_n};
      frame_cnt <= err_clr ? '0 : (&frame_cnt) ? frame_cnt : frame_cnt + CNT_W'(v_n);
      err_cnt <= err_clr ? '0 : err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_uart_frame_monitor.sv
// tb_uart_frame_monitor: directed frame table plus hand-written corner sequences
module tb_uart_frame_monitor;
  logic       pclk = 1'b0, preset_n = 1'b0, uart_net = 1'b1, cfg_en = 1'b0, err_clr = 1'b0;
  logic       cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [1:0] cfg_data_bits = 2'd3;
  logic       frame_valid, par_err, frm_err, glitch_err, baud_err;
  logic [7:0] frame_data;
  logic [3:0] err_status;
  logic [15:0] frame_cnt, err_cnt;
  int errors = 0, checks = 0;
  int nv = 0, np = 0, nf = 0, ng = 0, nb = 0;
  int v0, p0, f0, g0, b0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] db;
    bit         pe, po, s2, pflip, s2bad;
    logic [7:0] div;
    int         ev, ep, ef;
    logic [7:0] edata;
    int         fcnt, ecnt;
    logic [3:0] est;
  } vec_t;
  vec_t tbl[7];

  uart_frame_monitor dut (
    .pclk(pclk), .preset_n(preset_n), .uart_net(uart_net), .cfg_en(cfg_en),
    .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits), .cfg_par_en(cfg_par_en),
    .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2), .err_clr(err_clr),
    .frame_valid(frame_valid), .frame_data(frame_data), .par_err(par_err),
    .frm_err(frm_err), .glitch_err(glitch_err), .baud_err(baud_err),
    .err_status(err_status), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    nv += int'(frame_valid);
    np += int'(par_err);
    nf += int'(frm_err);
    ng += int'(glitch_err);
    nb += int'(baud_err);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic snap();
    v0 = nv; p0 = np; f0 = nf; g0 = ng; b0 = nb;
  endtask

  task automatic send(input logic [7:0] d, input int nbits, input bit pe, input bit pbit,
                      input bit two, input bit s2v, input int p, input int sb, input int sh, input int idle);
    uart_net = 1'b0;
    cyc(p);
    for (int i = 0; i < nbits; i++) begin
      if (i == sb) begin
        cyc(sh);
        uart_net = d[i];
        cyc(p - sh);
      end else begin
        uart_net = d[i];
        cyc(p);
      end
    end
    if (pe) begin
      uart_net = pbit;
      cyc(p);
    end
    uart_net = 1'b1;
    cyc(p);
    if (two) begin
      uart_net = s2v;
      cyc(p);
    end
    uart_net = 1'b1;
    cyc(idle);
  endtask

  initial begin
    logic [7:0] m;
    bit pb;
    tbl[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1, 0, 0, 8'hA5, 1, 0, 4'b0000};
    tbl[1] = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1, 1, 0, 8'h35, 2, 1, 4'b0001};
    tbl[2] = '{8'h5A, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 0, 0, 1, 8'h35, 2, 2, 4'b0011};
    tbl[3] = '{8'h1F, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1, 0, 0, 8'h1F, 3, 2, 4'b0011};
    tbl[4] = '{8'hFF, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1, 0, 0, 8'h3F, 4, 2, 4'b0011};
    tbl[5] = '{8'h00, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1, 0, 0, 8'h00, 5, 2, 4'b0011};
    tbl[6] = '{8'h35, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 0, 1, 1, 8'h00, 5, 4, 4'b0011};
    cyc(3);
    chk("rst_valid", int'(frame_valid), 0);
    chk("rst_data", int'(frame_data), 0);
    chk("rst_status", int'(err_status), 0);
    chk("rst_fcnt", int'(frame_cnt), 0);
    chk("rst_ecnt", int'(err_cnt), 0);
    chk("rst_pulses", nv + np + nf + ng + nb, 0);
    preset_n = 1'b1;
    cfg_en = 1'b1;
    cyc(5);
    for (int i = 0; i < 7; i++) begin
      cfg_div = tbl[i].div;
      cfg_data_bits = tbl[i].db;
      cfg_par_en = tbl[i].pe;
      cfg_par_odd = tbl[i].po;
      cfg_stop2 = tbl[i].s2;
      m = 8'((1 << (int'(tbl[i].db) + 5)) - 1);
      pb = (^(tbl[i].d & m)) ^ tbl[i].po ^ tbl[i].pflip;
      snap();
      send(tbl[i].d, int'(tbl[i].db) + 5, tbl[i].pe, pb, tbl[i].s2, ~tbl[i].s2bad,
           16 * (int'(tbl[i].div) + 1), -1, 0, 4);
      chk($sformatf("v%0d_valid", i), nv - v0, tbl[i].ev);
      chk($sformatf("v%0d_par", i), np - p0, tbl[i].ep);
      chk($sformatf("v%0d_frm", i), nf - f0, tbl[i].ef);
      chk($sformatf("v%0d_data", i), int'(frame_data), int'(tbl[i].edata));
      chk($sformatf("v%0d_fcnt", i), int'(frame_cnt), tbl[i].fcnt);
      chk($sformatf("v%0d_ecnt", i), int'(err_cnt), tbl[i].ecnt);
      chk($sformatf("v%0d_status", i), int'(err_status), int'(tbl[i].est));
    end
    cfg_div = '0;
    cfg_data_bits = 2'd3;
    cfg_par_en = 1'b0;
    cfg_par_odd = 1'b0;
    cfg_stop2 = 1'b0;
    snap();
    uart_net = 1'b0;
    cyc(3);
    uart_net = 1'b1;
    cyc(48);
    chk("glitch_pulse", ng - g0, 1);
    chk("glitch_novalid", nv - v0, 0);
    chk("glitch_fcnt", int'(frame_cnt), 5);
    chk("glitch_ecnt", int'(err_cnt), 5);
    chk("glitch_status", int'(err_status), 4'b0111);
    snap();
    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16, 3, 5, 4);
    chk("baud_pulse", nb - b0, 1);
    chk("baud_valid", nv - v0, 1);
    chk("baud_data", int'(frame_data), 8'hA5);
    chk("baud_ecnt", int'(err_cnt), 6);
    chk("baud_status", int'(err_status), 4'b1111);
    snap();
    send(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, 0, 0);
    send(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, 0, 4);
    chk("b2b_valid", nv - v0, 2);
    chk("b2b_data", int'(frame_data), 8'h22);
    chk("b2b_fcnt", int'(frame_cnt), 8);
    chk("b2b_errs", (np - p0) + (nf - f0) + (ng - g0) + (nb - b0), 0);
    snap();
    uart_net = 1'b0;
    cyc(48);
    cfg_en = 1'b0;
    uart_net = 1'b1;
    cyc(5);
    cfg_en = 1'b1;
    cyc(200);
    chk("dis_pulses", (nv - v0) + (np - p0) + (nf - f0) + (ng - g0) + (nb - b0), 0);
    chk("dis_fcnt", int'(frame_cnt), 8);
    chk("dis_ecnt", int'(err_cnt), 6);
    snap();
    uart_net = 1'b0;
    cyc(3);
    uart_net = 1'b1;
    cyc(8);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(40);
    chk("clr_glitch", ng - g0, 1);
    chk("clr_ecnt", int'(err_cnt), 0);
    chk("clr_fcnt", int'(frame_cnt), 0);
    chk("clr_status", int'(err_status), 0);
    uart_net = 1'b0;
    cyc(3);
    uart_net = 1'b1;
    cyc(48);
    chk("post_clr_ecnt", int'(err_cnt), 1);
    chk("post_clr_status", int'(err_status), 4'b0100);
    snap();
    uart_net = 1'b0;
    cyc(16 * 5 + 4);
    preset_n = 1'b0;
    uart_net = 1'b1;
    cyc(2);
    chk("mrst_fcnt", int'(frame_cnt), 0);
    chk("mrst_ecnt", int'(err_cnt), 0);
    chk("mrst_status", int'(err_status), 0);
    chk("mrst_data", int'(frame_data), 0);
    cyc(3);
    preset_n = 1'b1;
    cyc(5);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, 0, 4);
    chk("mrst_valid", nv - v0, 1);
    chk("mrst_errs", (np - p0) + (nf - f0) + (ng - g0) + (nb - b0), 0);
    chk("mrst_newdata", int'(frame_data), 8'h3C);
    chk("mrst_newfcnt", int'(frame_cnt), 1);
    chk("mrst_newecnt", int'(err_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
